// File: rtl/trace_capture.sv
// Commit-trace recorder: samples every retiring instruction into a FWFT FIFO until the halt rule fires.
// Head record is visible one edge after push; out_* hold while out_valid && !out_ready; pushes into a full FIFO are dropped.

// Generic first-word-fall-through FIFO; head visible the edge after the first write.
// Writes are accepted when not full or when the head is popped on the same edge.
module fifo #(
  parameter int W      = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              core_clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              wr_vld,
  input  logic [W-1:0]      wr_dat,
  output logic              wr_rdy,
  output logic              rd_vld,
  output logic [W-1:0]      rd_dat,
  input  logic              rd_rdy,
  output logic [ADDR_W:0]   level
);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_fire;
  logic              rd_fire;

  assign rd_vld  = (level != '0);
  assign rd_dat  = mem[rd_ptr];
  assign rd_fire = rd_vld && rd_rdy;
  // a full FIFO can still take a write if the head leaves on the same edge
  assign wr_rdy  = (level != LVL_FULL) || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end
endmodule

module trace_capture #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int MIN_COUNT = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_wb_en,
  output logic [4:0]        out_wb_addr,
  output logic [31:0]       out_wb_data,
  output logic [ADDR_W:0]   level,
  output logic [31:0]       count,
  output logic              overflow,
  output logic              halted
);
  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } rec_t;

  state_t state, state_nxt;
  logic   push_vld;
  logic   push_rdy;
  logic   halt_hit;
  rec_t   rec_in;
  rec_t   head;

  assign halt_hit = (count >= 32'(MIN_COUNT)) && (inst == 32'h0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_vld  = 1'b0;
    if (clr) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (halt_hit) state_nxt = HALT;
          else          push_vld  = 1'b1;
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = RUN;
      endcase
    end
  end

  // writes to $0 are architecturally invisible, so they are recorded as no write
  always_comb begin
    rec_in.pc      = pc;
    rec_in.inst    = inst;
    rec_in.wb_en   = wb_en && (wb_addr != 5'd0);
    rec_in.wb_addr = wb_addr;
    rec_in.wb_data = wb_data;
  end

  fifo #(
    .W      ($bits(rec_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .core_clk (clk),
    .arst_n   (reset),
    .clr      (clr),
    .wr_vld   (push_vld),
    .wr_dat   (rec_in),
    .wr_rdy   (push_rdy),
    .rd_vld   (out_valid),
    .rd_dat   (head),
    .rd_rdy   (out_ready),
    .level    (level)
  );

  // count tracks observed instructions, including ones dropped on overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (push_vld) begin
      if (count != 32'hFFFF_FFFF) count <= count + 32'd1;
      if (!push_rdy) overflow <= 1'b1;
    end
  end

  assign halted      = (state == HALT);
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_wb_en   = head.wb_en;
  assign out_wb_addr = head.wb_addr;
  assign out_wb_data = head.wb_data;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: vector table for capture basics plus hand sequences for halt, overflow, full push/pop, clr and async reset.
module tb_trace_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic [31:0] pc, inst, wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_wb_data;
  logic        out_wb_en;
  logic [4:0]  out_wb_addr;
  logic [4:0]  level;
  logic [31:0] count;
  logic        overflow, halted;

  int errors = 0;
  int checks = 0;

  trace_capture #(.DEPTH(16), .ADDR_W(4), .MIN_COUNT(20)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .pc(pc), .inst(inst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_wb_en(out_wb_en),
    .out_wb_addr(out_wb_addr), .out_wb_data(out_wb_data),
    .level(level), .count(count), .overflow(overflow), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wbe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_wbe;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [4:0]  e_lvl;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] i_, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    pc = p; inst = i_; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

    // vectors applied back to back from reset release, out_ready per row
    tbl[0] = '{1'b1, 32'h00400000, 32'h24010001, 1'b1, 5'd1, 32'h1,
               32'h00400000, 32'h24010001, 1'b1, 5'd1, 32'h1, 5'd1, 32'd1};
    tbl[1] = '{1'b1, 32'h00400004, 32'h24010001, 1'b1, 5'd1, 32'h1,
               32'h00400004, 32'h24010001, 1'b1, 5'd1, 32'h1, 5'd1, 32'd2};
    tbl[2] = '{1'b1, 32'h00400008, 32'h24010001, 1'b1, 5'd1, 32'h1,
               32'h00400008, 32'h24010001, 1'b1, 5'd1, 32'h1, 5'd1, 32'd3};
    tbl[3] = '{1'b1, 32'h0040000C, 32'h00000000, 1'b0, 5'd0, 32'h0,
               32'h0040000C, 32'h00000000, 1'b0, 5'd0, 32'h0, 5'd1, 32'd4};
    tbl[4] = '{1'b1, 32'h00400010, 32'h00000820, 1'b1, 5'd0, 32'hDEADBEEF,
               32'h00400010, 32'h00000820, 1'b0, 5'd0, 32'hDEADBEEF, 5'd1, 32'd5};
    tbl[5] = '{1'b1, 32'h00400014, 32'h00000000, 1'b0, 5'd0, 32'h0,
               32'h00400014, 32'h00000000, 1'b0, 5'd0, 32'h0, 5'd1, 32'd6};
    tbl[6] = '{1'b0, 32'h00400018, 32'h11111111, 1'b1, 5'd3, 32'h00400018,
               32'h00400014, 32'h00000000, 1'b0, 5'd0, 32'h0, 5'd2, 32'd7};
    tbl[7] = '{1'b0, 32'h0040001C, 32'h22222222, 1'b1, 5'd3, 32'h0040001C,
               32'h00400014, 32'h00000000, 1'b0, 5'd0, 32'h0, 5'd3, 32'd8};
    tbl[8] = '{1'b1, 32'h00400020, 32'h33333333, 1'b1, 5'd3, 32'h00400020,
               32'h00400018, 32'h11111111, 1'b1, 5'd3, 32'h00400018, 5'd3, 32'd9};
    tbl[9] = '{1'b1, 32'h00400024, 32'h44444444, 1'b1, 5'd3, 32'h00400024,
               32'h0040001C, 32'h22222222, 1'b1, 5'd3, 32'h0040001C, 5'd3, 32'd10};

    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_level", {27'b0, level}, 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_wb_data", out_wb_data, 32'd0);
    #8 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      out_ready = tbl[i].rdy;
      drive(tbl[i].pc, tbl[i].inst, tbl[i].wbe, tbl[i].wa, tbl[i].wd);
      step();
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), out_inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d_wb_en", i), {31'b0, out_wb_en}, {31'b0, tbl[i].e_wbe});
      chk($sformatf("tbl%0d_wb_addr", i), {27'b0, out_wb_addr}, {27'b0, tbl[i].e_wa});
      chk($sformatf("tbl%0d_wb_data", i), out_wb_data, tbl[i].e_wd);
      chk($sformatf("tbl%0d_level", i), {27'b0, level}, {27'b0, tbl[i].e_lvl});
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
    end

    do_clr();
    chk("clr_level", {27'b0, level}, 32'd0);
    chk("clr_count", count, 32'd0);
    chk("clr_valid", {31'b0, out_valid}, 32'd0);

    // overflow: 20 pushes into a stalled FIFO, then halt and drain
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(32'h1000 + 32'(4 * k), 32'h100 + 32'(k), 1'b1, 5'd2, 32'(k));
      step();
    end
    chk("ovf_level", {27'b0, level}, 32'd16);
    chk("ovf_overflow", {31'b0, overflow}, 32'd1);
    chk("ovf_count", count, 32'd20);
    drive(32'h1050, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("ovf_halted", {31'b0, halted}, 32'd1);
    chk("ovf_halt_count", count, 32'd20);
    chk("ovf_halt_level", {27'b0, level}, 32'd16);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("drain%0d_pc", k), out_pc, 32'h1000 + 32'(4 * k));
      drive(32'h2222, 32'h3333, 1'b1, 5'd2, 32'h0);
      step();
    end
    chk("drain_empty", {31'b0, out_valid}, 32'd0);
    chk("drain_level", {27'b0, level}, 32'd0);
    chk("drain_overflow", {31'b0, overflow}, 32'd1);
    chk("drain_count", count, 32'd20);

    // clr out of HALT resumes capture
    do_clr();
    chk("clrh_halted", {31'b0, halted}, 32'd0);
    chk("clrh_overflow", {31'b0, overflow}, 32'd0);
    chk("clrh_count", count, 32'd0);
    drive(32'h3000, 32'h5, 1'b1, 5'd4, 32'h77);
    step();
    chk("clrh_valid", {31'b0, out_valid}, 32'd1);
    chk("clrh_pc", out_pc, 32'h3000);
    chk("clrh_count1", count, 32'd1);

    // halt after 25 nonzero instructions
    do_clr();
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      drive(32'h4000 + 32'(4 * k), 32'h200 + 32'(k), 1'b1, 5'd2, 32'(k));
      step();
    end
    chk("halt_pre_count", count, 32'd25);
    chk("halt_pre_halted", {31'b0, halted}, 32'd0);
    drive(32'h4064, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_count", count, 32'd25);
    chk("halt_level", {27'b0, level}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(32'h5000, 32'h7, 1'b1, 5'd2, 32'h9);
      step();
    end
    chk("halt_frozen_count", count, 32'd25);
    chk("halt_frozen_level", {27'b0, level}, 32'd0);
    chk("halt_frozen_halted", {31'b0, halted}, 32'd1);

    // full FIFO with simultaneous push and pop
    do_clr();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(32'h6000 + 32'(4 * k), 32'h300 + 32'(k), 1'b1, 5'd5, 32'(k));
      step();
    end
    chk("full_level", {27'b0, level}, 32'd16);
    chk("full_overflow", {31'b0, overflow}, 32'd0);
    chk("full_head", out_pc, 32'h6000);
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      drive(32'h6000 + 32'(4 * (15 + j)), 32'h300 + 32'(15 + j), 1'b1, 5'd5, 32'(j));
      step();
      chk($sformatf("pp%0d_level", j), {27'b0, level}, 32'd16);
      chk($sformatf("pp%0d_pc", j), out_pc, 32'h6000 + 32'(4 * j));
    end
    chk("pp_overflow", {31'b0, overflow}, 32'd0);
    chk("pp_count", count, 32'd24);

    // asynchronous reset mid-drain
    do_clr();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(32'h7000 + 32'(4 * k), 32'h400 + 32'(k), 1'b1, 5'd6, 32'(k));
      step();
    end
    chk("ar_pre_level", {27'b0, level}, 32'd8);
    out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_level", {27'b0, level}, 32'd0);
    chk("ar_count", count, 32'd0);
    step();
    chk("ar_hold_level", {27'b0, level}, 32'd0);
    chk("ar_hold_count", count, 32'd0);
    #2 reset = 1'b1;
    out_ready = 1'b0;
    drive(32'h8000, 32'h9, 1'b1, 5'd7, 32'h1);
    step();
    chk("ar_resume_count", count, 32'd1);
    chk("ar_resume_level", {27'b0, level}, 32'd1);
    chk("ar_resume_pc", out_pc, 32'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable commit-trace recorder that sits directly downstream of sccomp_dataflow.
- Each cycle it samples the retiring instruction's pc, inst and register-file writeback.
- It buffers these as records in a first-word-fall-through FIFO and drains them over a valid/ready stream to a UART or host dump engine.
- It stops capturing on the same end-of-program rule the team uses in simulation: a null instruction once at least MIN_COUNT instructions have retired.

Parameters:
- DEPTH, 16: FIFO depth in records; power of two, at least 2.
- ADDR_W, 4: log2(DEPTH).
- MIN_COUNT, 20: number of retired instructions that must be observed before inst==32'h00000000 is treated as halt.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous restart: empties the FIFO, clears count, overflow and halted, and enters RUN.
- pc  input  32  pc of the instruction retiring this cycle.
- inst  input  32  instruction retiring this cycle.
- wb_en  input  1  register-file write enable this cycle.
- wb_addr  input  5  register-file write address.
- wb_data  input  32  register-file write data.
- out_valid  output  1  head record is present.
- out_ready  input  1  consumer accepts the head record.
- out_pc  output  32  head record pc.
- out_inst  output  32  head record instruction.
- out_wb_en  output  1  head record write enable; forced to 0 when wb_addr==0.
- out_wb_addr  output  5  head record write address.
- out_wb_data  output  32  head record write data.
- level  output  ADDR_W+1  number of records currently held (0..DEPTH).
- count  output  32  number of instructions observed since reset or clr.
- overflow  output  1  sticky: set when a record was dropped because the FIFO was full.
- halted  output  1  the halt rule has fired.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO emptied; read and write pointers at 0; level=0; out_valid=0.
  - Data outputs driven to 0.
  - count=0, overflow=0, halted=0; state=RUN.
- Any clock edge with reset==0 is ignored. Reset asserted mid-drain discards all buffered records immediately.
- State machine:
  - RUN: each edge evaluates the halt rule (count >= MIN_COUNT) && (inst == 0).
    - If true: go to HALT, set halted=1, no record is pushed, count is not incremented.
    - Otherwise: count += 1; push {pc, inst, wb_en & (wb_addr!=0), wb_addr, wb_data}.
  - HALT: no pushes and count frozen. Draining continues until empty. Leave HALT only on clr or reset.
- inst==0 with count < MIN_COUNT is a normal nop: it is recorded and counted.
- FIFO:
  - Push latency: a record pushed on edge N appears at the head (out_valid=1) after edge N when the FIFO was empty. There is no combinational bypass from inputs to outputs.
  - Pop occurs on an edge where out_valid && out_ready. out_* remain stable while out_valid && !out_ready.
  - Full and push with no pop: record dropped, overflow set to 1, count still increments.
  - Full and push with a simultaneous pop: both succeed, level stays DEPTH, overflow unchanged.
  - Empty and push with out_ready=1: push only, since a pop needs out_valid at that edge.
  - Pointers wrap modulo DEPTH. level is a separate counter, or pointer difference with an extra wrap bit.
- count saturates at 32'hFFFFFFFF.
- clr has priority over push and pop on the same edge.
- out_* data are don't-care while out_valid==0 but are held at the last value; the bench checks them only under valid.

Test Plan:
1. Basic capture: reset low 10 ns then high; 3 instructions at pc 0x00400000/04/08 with inst 0x24010001 (wb_en=1, addr 1, data 1); out_ready=1 -> three records in order, out_pc 0x00400000, 0x00400004, 0x00400008; count=3; level returns to 0.
2. Halt rule: 25 nonzero instructions, then inst=0 -> count stops at 25; halted=1 on the edge where inst=0 is sampled; later inputs ignored. Separately, inst=0 at count=5 is recorded and count becomes 6.
3. Backpressure/overflow: out_ready=0 and 20 pushes with DEPTH=16 -> level=16, overflow=1, count=20. Then out_ready=1 -> exactly 16 records with pc of instructions 1..16; overflow stays 1.
4. Simultaneous push/pop at full: fill 16, then out_ready=1 while pushing -> level stays 16 each cycle, no drop, overflow=0, records strictly in order.
5. Write to $0: wb_en=1, wb_addr=0, wb_data=0xDEADBEEF -> out_wb_en=0, out_wb_addr=0.
6. Asynchronous reset mid-drain: level=8, reset pulled low between edges -> out_valid=0, level=0 and count=0 immediately, without waiting for clk. After release, capture resumes from count=0. Separately, clr in HALT -> halted=0 and capture resumes.
